// File: rtl/mips_dcache_if.sv
// Core- and memory-facing signal bundle of the MIPS data cache.
// Latency: none (wiring only).
// Backpressure: core holds its request until hit; memory is fixed-latency with no handshake.
interface mips_dcache_if;
    logic        cache_en;
    logic        cache_write_en;
    logic [31:0] cache_addr;
    logic [7:0]  cache_data_in  [0:3];
    logic [7:0]  cache_data_out [0:3];
    logic        hit;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_out [0:3];
    logic [7:0]  mem_data_in  [0:3];
    logic        mem_write_en;

    // cache side: responder to the core, initiator to memory
    modport slave (
        input  cache_en, cache_write_en, cache_addr, cache_data_in, mem_data_out,
        output cache_data_out, hit, mem_addr, mem_data_in, mem_write_en
    );

    // environment side: the core plus the data memory
    modport master (
        output cache_en, cache_write_en, cache_addr, cache_data_in, mem_data_out,
        input  cache_data_out, hit, mem_addr, mem_data_in, mem_write_en
    );
endinterface

// File: rtl/mips_dcache.sv
// Direct-mapped write-through write-allocate data cache; `DCACHE_STATS_EN adds hit/miss counters.
// Latency: load hit 0 cycles; load miss and every store complete MEM_LATENCY+1 cycles after request.
// Backpressure: core holds cache_en until hit; memory is fixed-latency, so no memory-side stall.
module mips_dcache #(
    parameter int INDEX_BITS  = 8,
    parameter int MEM_LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst_b,
    mips_dcache_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);
    localparam int NLINES   = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_WDONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic [29:0]           r_waddr;
    logic [31:0]           r_wdata;
    logic [NLINES-1:0]     r_valid;
    logic [TAG_BITS-1:0]   r_tag  [NLINES];
    logic [31:0]           r_data [NLINES];

    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_lookup;
    logic                  w_last;
    logic [31:0]           w_rd_line;
    logic [31:0]           w_mem_rdata;
    logic [31:0]           w_req_wdata;
    logic [31:0]           w_line_dat;
    logic                  w_line_we;
    logic                  w_latch;
    logic                  w_hit;
    logic                  w_unused;

    // byte offset is irrelevant: everything works on whole words
    assign w_unused  = ^bus.cache_addr[1:0];
    assign w_index   = bus.cache_addr[INDEX_BITS+1:2];
    assign w_tag     = bus.cache_addr[31:INDEX_BITS+2];
    assign w_lookup  = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_last    = (r_cnt == 4'(MEM_LATENCY - 1));
    // invalid lines read as zero so nothing unreset ever reaches the core
    assign w_rd_line = r_valid[w_index] ? r_data[w_index] : 32'h0;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign bus.cache_data_out[g]    = w_rd_line[31-8*g -: 8];
        assign bus.mem_data_in[g]       = (r_state == S_WRITE) ? r_wdata[31-8*g -: 8] : 8'h00;
        assign w_mem_rdata[31-8*g -: 8] = bus.mem_data_out[g];
        assign w_req_wdata[31-8*g -: 8] = bus.cache_data_in[g];
    end

    assign bus.hit          = w_hit;
    assign bus.mem_write_en = (r_state == S_WRITE);
    assign bus.mem_addr     = ((r_state == S_FILL) || (r_state == S_WRITE)) ? {r_waddr, 2'b00} : 32'h0;

    // next-state, hit and line-update decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hit       = 1'b0;
        w_latch     = 1'b0;
        w_line_we   = 1'b0;
        w_line_dat  = r_wdata;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 4'd0;
                if (bus.cache_en) begin
                    if (bus.cache_write_en) begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_WRITE;
                    end else if (w_lookup) begin
                        w_hit = 1'b1;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_FILL;
                    end
                end
            end
            S_FILL: begin
                w_cnt_nxt = r_cnt + 4'd1;
                if (w_last) begin
                    w_line_we   = 1'b1;
                    w_line_dat  = w_mem_rdata;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                w_cnt_nxt = r_cnt + 4'd1;
                if (w_last) begin
                    w_line_we   = 1'b1;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_WDONE;
                end
            end
            S_WDONE: begin
                w_hit       = bus.cache_en;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // state and wait counter
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // capture the request so the line update ignores later changes on the core inputs
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_waddr <= 30'h0;
            r_wdata <= 32'h0;
        end else if (w_latch) begin
            r_waddr <= bus.cache_addr[31:2];
            r_wdata <= w_req_wdata;
        end
    end

    // valid bits: cleared by reset, set when a line is filled or allocated
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_valid <= '0;
        end else if (w_line_we) begin
            r_valid[r_waddr[INDEX_BITS-1:0]] <= 1'b1;
        end
    end

    // tag and data arrays, written only at the end of a memory access
    always_ff @(posedge clk) begin
        if (w_line_we) begin
            r_tag[r_waddr[INDEX_BITS-1:0]]  <= r_waddr[29:INDEX_BITS];
            r_data[r_waddr[INDEX_BITS-1:0]] <= w_line_dat;
        end
    end

`ifdef DCACHE_STATS_EN
    logic w_stat_hit;
    logic w_stat_miss;

    // a store counts by its lookup before the write; a load hit counts every IDLE hit cycle
    assign w_stat_hit  = (r_state == S_IDLE) && bus.cache_en && w_lookup;
    assign w_stat_miss = (r_state == S_IDLE) && bus.cache_en && !w_lookup;

    // saturating hit and miss counters
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            if (w_stat_hit && (hit_count != 32'hFFFF_FFFF)) hit_count <= hit_count + 32'd1;
            if (w_stat_miss && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mips_dcache.sv
// Self-checking bench for mips_dcache against a word-level cache/memory model.
// Latency: checks request-to-hit cycle counts for hits, misses and stores.
// Backpressure: bench plays the core (holds request until hit) and a fixed-latency memory.
`timescale 1ns/1ps
module tb_mips_dcache;
    localparam int IB = 8;
    localparam int L  = 4;
    localparam int NL = 1 << IB;

    logic clk   = 1'b0;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    mips_dcache_if bus();
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    mips_dcache #(.INDEX_BITS(IB), .MEM_LATENCY(L)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // memory contents as the system should see them, plus expected cache contents
    logic [31:0] mem_model [logic [29:0]];
    bit          m_valid [NL];
    logic [31:0] m_tag   [NL];
    logic [31:0] m_data  [NL];
    logic [31:0] mem_v;

    function automatic logic [31:0] mem_rd(input logic [29:0] wa);
        if (mem_model.exists(wa)) return mem_model[wa];
        return {wa[15:0], ~wa[15:0]} ^ 32'hA5C3_0F1E;
    endfunction

    // memory returns the word at the address it is being driven with
    always @(negedge clk) begin
        mem_v = mem_rd(bus.mem_addr[31:2]);
        for (int i = 0; i < 4; i++) bus.mem_data_out[i] = mem_v[31-8*i -: 8];
    end

    task automatic model_reset();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_load(input logic [31:0] a, output int lat, output logic [31:0] d);
        int          idx;
        logic [31:0] tg;
        idx = int'((a >> 2) % NL);
        tg  = a / (NL * 4);
        if (m_valid[idx] && m_tag[idx] == tg) begin
            lat = 0;
        end else begin
            lat         = L + 1;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_data[idx]  = mem_rd(a[31:2]);
        end
        d = m_data[idx];
    endtask

    task automatic model_store(input logic [31:0] a, input logic [31:0] wd);
        int idx;
        idx          = int'((a >> 2) % NL);
        m_valid[idx] = 1'b1;
        m_tag[idx]   = a / (NL * 4);
        m_data[idx]  = wd;
        mem_model[a[31:2]] = wd;
    endtask

    // one core request, held until hit or until the cycle budget expires (lat stays -1)
    task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output int wcyc,
                          output logic [31:0] maddr, output logic [31:0] wdat);
        lat = -1; rd = '0; wcyc = 0; maddr = '0; wdat = '0;
        @(negedge clk);
        bus.cache_en       = 1'b1;
        bus.cache_write_en = we;
        bus.cache_addr     = a;
        for (int i = 0; i < 4; i++) bus.cache_data_in[i] = wd[31-8*i -: 8];
        for (int c = 0; c < 40; c++) begin
            #1;
            if (c == 1) maddr = bus.mem_addr;
            if (bus.mem_write_en) begin
                wcyc++;
                wdat = {bus.mem_data_in[0], bus.mem_data_in[1], bus.mem_data_in[2], bus.mem_data_in[3]};
            end
            if (bus.hit) begin
                lat = c;
                rd  = {bus.cache_data_out[0], bus.cache_data_out[1], bus.cache_data_out[2], bus.cache_data_out[3]};
                break;
            end
            @(negedge clk);
        end
        bus.cache_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] md, cd;
        bus.cache_en = 1'b0; bus.cache_write_en = 1'b0; bus.cache_addr = '0;
        for (int i = 0; i < 4; i++) bus.cache_data_in[i] = 8'h00;
        #2 rst_b = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        md = {bus.mem_data_in[0], bus.mem_data_in[1], bus.mem_data_in[2], bus.mem_data_in[3]};
        cd = {bus.cache_data_out[0], bus.cache_data_out[1], bus.cache_data_out[2], bus.cache_data_out[3]};
        n_checks++; if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got=%b exp=0", bus.hit); end
        n_checks++; if (bus.mem_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_mwe got=%b exp=0", bus.mem_write_en); end
        n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_maddr got=%h exp=0", bus.mem_addr); end
        n_checks++; if (md !== 32'h0) begin n_fail++; $display("FAIL reset_mdata got=%h exp=0", md); end
        n_checks++; if (cd !== 32'h0) begin n_fail++; $display("FAIL reset_cdout got=%h exp=0", cd); end
        rst_b = 1'b1;
        model_reset();
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        int lat, elat, wc, eh, em;
        logic [31:0] rd, ed, ma, wd;
        eh = 0; em = 0;
        n_checks++; if (hit_count !== 32'h0) begin n_fail++; $display("FAIL stats_reset_hit got=%0d exp=0", hit_count); end
        n_checks++; if (miss_count !== 32'h0) begin n_fail++; $display("FAIL stats_reset_miss got=%0d exp=0", miss_count); end
        for (int k = 0; k < 3; k++) begin
            model_load(32'h500, elat, ed);
            if (elat != 0) em++;
            eh++;
            do_req(1'b0, 32'h500, 32'h0, lat, rd, wc, ma, wd);
        end
        @(negedge clk); #1;
        n_checks++; if (hit_count !== 32'(eh)) begin n_fail++; $display("FAIL stats_hit got=%0d exp=%0d", hit_count, eh); end
        n_checks++; if (miss_count !== 32'(em)) begin n_fail++; $display("FAIL stats_miss got=%0d exp=%0d", miss_count, em); end
    endtask
`endif

    task automatic test_load_miss();
        int lat, elat, wc;
        logic [31:0] rd, ed, ma, wd;
        mem_model[30'h10] = 32'hDEAD_BEEF;
        for (int k = 0; k < 2; k++) begin
            model_load(32'h40, elat, ed);
            do_req(1'b0, 32'h40, 32'h0, lat, rd, wc, ma, wd);
            n_checks++; if (lat != elat) begin n_fail++; $display("FAIL load_lat pass=%0d got=%0d exp=%0d", k, lat, elat); end
            n_checks++; if (rd !== ed) begin n_fail++; $display("FAIL load_data pass=%0d got=%h exp=%h", k, rd, ed); end
            n_checks++; if (wc != 0) begin n_fail++; $display("FAIL load_mwe pass=%0d got=%0d exp=0", k, wc); end
            if (elat != 0) begin
                n_checks++; if (ma !== 32'h40) begin n_fail++; $display("FAIL load_maddr got=%h exp=00000040", ma); end
            end
        end
    endtask

    task automatic test_store();
        int lat, elat, wc;
        logic [31:0] rd, ed, ma, wd;
        model_store(32'h80, 32'h1122_3344);
        do_req(1'b1, 32'h80, 32'h1122_3344, lat, rd, wc, ma, wd);
        n_checks++; if (lat != L + 1) begin n_fail++; $display("FAIL store_lat got=%0d exp=%0d", lat, L + 1); end
        n_checks++; if (wc != L) begin n_fail++; $display("FAIL store_mwe_cycles got=%0d exp=%0d", wc, L); end
        n_checks++; if (ma !== 32'h80) begin n_fail++; $display("FAIL store_maddr got=%h exp=00000080", ma); end
        n_checks++; if (wd !== 32'h1122_3344) begin n_fail++; $display("FAIL store_mdata got=%h exp=11223344", wd); end
        n_checks++; if (rd !== 32'h1122_3344) begin n_fail++; $display("FAIL store_line got=%h exp=11223344", rd); end
        #1;
        n_checks++; if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL store_hit_en_low got=%b exp=0", bus.hit); end
        @(negedge clk); #1;
        n_checks++; if (bus.mem_write_en !== 1'b0) begin n_fail++; $display("FAIL store_idle_mwe got=%b exp=0", bus.mem_write_en); end
        model_load(32'h80, elat, ed);
        do_req(1'b0, 32'h80, 32'h0, lat, rd, wc, ma, wd);
        n_checks++; if (lat != elat) begin n_fail++; $display("FAIL store_reload_lat got=%0d exp=%0d", lat, elat); end
        n_checks++; if (rd !== ed) begin n_fail++; $display("FAIL store_reload_data got=%h exp=%h", rd, ed); end
    endtask

    task automatic test_conflict();
        int lat, elat, wc;
        logic [31:0] rd, ed, ma, wd;
        logic [31:0] tbl [3];
        tbl[0] = 32'h40; tbl[1] = 32'h440; tbl[2] = 32'h43;
        for (int k = 0; k < 3; k++) begin
            model_load(tbl[k], elat, ed);
            do_req(1'b0, tbl[k], 32'h0, lat, rd, wc, ma, wd);
            n_checks++; if (lat != elat) begin n_fail++; $display("FAIL conflict_lat addr=%h got=%0d exp=%0d", tbl[k], lat, elat); end
            n_checks++; if (rd !== ed) begin n_fail++; $display("FAIL conflict_data addr=%h got=%h exp=%h", tbl[k], rd, ed); end
            if (elat != 0) begin
                n_checks++;
                if (ma !== (tbl[k] & 32'hFFFF_FFFC)) begin
                    n_fail++; $display("FAIL conflict_maddr addr=%h got=%h exp=%h", tbl[k], ma, tbl[k] & 32'hFFFF_FFFC);
                end
            end
        end
    endtask

    task automatic test_midfill();
        int lat, elat, wc, hits, bad;
        logic [31:0] rd, ed, ma, wd;
        hits = 0; bad = 0;
        @(negedge clk);
        bus.cache_en = 1'b1; bus.cache_write_en = 1'b0; bus.cache_addr = 32'h300;
        for (int c = 0; c < L + 4; c++) begin
            #1;
            if (bus.hit) hits++;
            if (c >= 1 && c <= L && (bus.mem_addr !== 32'h300 || bus.mem_write_en !== 1'b0)) bad++;
            if (c == 2) begin bus.cache_en = 1'b0; bus.cache_addr = 32'h304; end
            @(negedge clk);
        end
        n_checks++; if (hits != 0) begin n_fail++; $display("FAIL midfill_hit got=%0d exp=0", hits); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL midfill_mem got=%0d bad cycles exp=0", bad); end
        model_load(32'h300, elat, ed);
        model_load(32'h300, elat, ed);
        do_req(1'b0, 32'h300, 32'h0, lat, rd, wc, ma, wd);
        n_checks++; if (lat != elat) begin n_fail++; $display("FAIL midfill_orig_lat got=%0d exp=%0d", lat, elat); end
        n_checks++; if (rd !== ed) begin n_fail++; $display("FAIL midfill_orig_data got=%h exp=%h", rd, ed); end
        model_load(32'h304, elat, ed);
        do_req(1'b0, 32'h304, 32'h0, lat, rd, wc, ma, wd);
        n_checks++; if (lat != elat) begin n_fail++; $display("FAIL midfill_live_lat got=%0d exp=%0d", lat, elat); end
    endtask

    task automatic test_random();
        int lat, elat, wc;
        bit we;
        logic [31:0] a, d, rd, ed, ma, wd;
        for (int n = 0; n < 80; n++) begin
            we = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 3) << (IB + 2)) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            d  = $urandom;
            if (we) begin model_store(a, d); elat = L + 1; ed = d; end
            else model_load(a, elat, ed);
            do_req(we, a, d, lat, rd, wc, ma, wd);
            n_checks++; if (lat != elat) begin n_fail++; $display("FAIL rand_lat n=%0d we=%0d addr=%h got=%0d exp=%0d", n, we, a, lat, elat); end
            n_checks++; if (rd !== ed) begin n_fail++; $display("FAIL rand_data n=%0d addr=%h got=%h exp=%h", n, a, rd, ed); end
            n_checks++; if (wc != (we ? L : 0)) begin n_fail++; $display("FAIL rand_mwe n=%0d got=%0d exp=%0d", n, wc, we ? L : 0); end
            if (we) begin
                n_checks++; if (wd !== d) begin n_fail++; $display("FAIL rand_mdata n=%0d got=%h exp=%h", n, wd, d); end
            end
            if (elat != 0) begin
                n_checks++;
                if (ma !== (a & 32'hFFFF_FFFC)) begin n_fail++; $display("FAIL rand_maddr n=%0d got=%h exp=%h", n, ma, a & 32'hFFFF_FFFC); end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int lat, elat, wc;
        logic [31:0] rd, ed, ma, wd;
        @(negedge clk);
        bus.cache_en = 1'b1; bus.cache_write_en = 1'b1; bus.cache_addr = 32'h200;
        for (int i = 0; i < 4; i++) bus.cache_data_in[i] = 8'h5A;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (bus.mem_write_en !== 1'b1) begin n_fail++; $display("FAIL rstw_pre_mwe got=%b exp=1", bus.mem_write_en); end
        rst_b = 1'b0;
        bus.cache_en = 1'b0;
        #1;
        n_checks++; if (bus.mem_write_en !== 1'b0) begin n_fail++; $display("FAIL rstw_mwe got=%b exp=0", bus.mem_write_en); end
        n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rstw_maddr got=%h exp=0", bus.mem_addr); end
        @(negedge clk);
        rst_b = 1'b1;
        model_reset();
        model_load(32'h40, elat, ed);
        do_req(1'b0, 32'h40, 32'h0, lat, rd, wc, ma, wd);
        n_checks++; if (lat != elat) begin n_fail++; $display("FAIL rstw_reload_lat got=%0d exp=%0d", lat, elat); end
        n_checks++; if (rd !== ed) begin n_fail++; $display("FAIL rstw_reload_data got=%h exp=%h", rd, ed); end
    endtask

    initial begin
        test_reset();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        test_load_miss();
        test_store();
        test_conflict();
        test_midfill();
        test_random();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_dcache.md
Name: mips_dcache

Overview:
Direct-mapped, write-through, write-allocate data cache between the MIPS core's load/store path and the byte-lane data memory.
- Responder on the core side: cache_addr, cache_data_in, cache_en, cache_write_en in; cache_data_out, hit out.
- Initiator on the memory side: mem_addr, mem_data_in, mem_write_en out; mem_data_out in.
- Memory has a fixed access latency of MEM_LATENCY cycles.

Parameters:
- INDEX_BITS, 8: line index width; 2^INDEX_BITS one-word lines.
- MEM_LATENCY, 4: cycles memory needs per read or write; legal range 1..15.

Ports:
- clk  input  1  clock.
- rst_b  input  1  reset, asynchronous, active-low.
- cache_en  input  1  core request valid; held stable until hit.
- cache_write_en  input  1  1=store word, 0=load.
- cache_addr  input  32  byte address; bits [1:0] ignored.
- cache_data_in  input  8x4 unpacked [0:3]  store data; lane 0 = bits 31:24.
- cache_data_out  output  8x4 unpacked [0:3]  load data / current line contents.
- hit  output  1  request complete this cycle.
- mem_addr  output  32  word-aligned memory address.
- mem_data_out  input  8x4 unpacked [0:3]  read data from memory.
- mem_data_in  output  8x4 unpacked [0:3]  write data to memory.
- mem_write_en  output  1  memory write strobe.

Behaviour:
- Address split: tag = addr[31:INDEX_BITS+2], index = addr[INDEX_BITS+1:2].
- Per line storage: valid bit, tag, 4 data bytes.
- Reset (async): all valid bits 0, state IDLE, wait counter 0. Outputs: hit=0, mem_write_en=0, mem_addr=0, mem_data_in all 0, cache_data_out all 0. Data and tag arrays are not reset.
- cache_data_out is combinational from the line selected by cache_addr's index in every state, so the core can merge bytes for SB.
- State IDLE:
  - cache_en=1, load, valid and tag match: hit=1 combinationally in the same cycle; stay IDLE; zero-latency hit.
  - cache_en=1, load, miss: latch word-aligned address, go to FILL, counter=0.
  - cache_en=1, store: latch address and data, go to WRITE, counter=0. Stores always write through, whether they hit or miss.
  - cache_en=0: idle; hit=0.
- State FILL:
  - mem_addr = latched address; mem_write_en=0; counter increments each cycle.
  - When counter == MEM_LATENCY-1: write mem_data_out into the line, set valid, set tag, go to IDLE.
  - The next cycle is an IDLE read hit. Total load-miss latency = MEM_LATENCY+1 cycles from request to hit.
- State WRITE:
  - mem_addr = latched address; mem_data_in = latched data; mem_write_en=1 for all MEM_LATENCY cycles.
  - At the last cycle: write data into the line, set valid and tag (allocate), go to WDONE.
- State WDONE:
  - hit=1 for exactly one cycle, then IDLE. A store therefore completes MEM_LATENCY+1 cycles after the request.
  - If cache_en is low in WDONE, hit is still 0.
- Request changes mid-transaction (cache_en dropped or address changed during FILL/WRITE):
  - The in-flight memory access completes.
  - The line is updated with the latched address and data, never the live inputs.
- hit is never asserted in FILL or WRITE.
- Memory outputs hold their reset values while IDLE.
- Lines of different tag at the same index: replace unconditionally. There are no dirty lines, so there is no writeback.
- Counter width is 4 bits; it never wraps because of the MEM_LATENCY range.
- Reset asserted mid-FILL or mid-WRITE: immediate return to IDLE, mem_write_en drops asynchronously, all lines invalid.

Optional Feature:
DCACHE_STATS_EN
- Defined: adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments once per IDLE read hit and once per store whose pre-write lookup matched.
  - miss_count increments once on each IDLE→FILL transition and on each store miss.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then load 0x0000_0040 with MEM_LATENCY=4 and memory word {DE,AD,BE,EF} → hit=0 for 4 cycles, mem_write_en=0, mem_addr=0x40. Hit=1 on cycle 5 with cache_data_out={DE,AD,BE,EF}. Repeating the load gives hit in cycle 0.
- Store {11,22,33,44} to 0x0000_0080 → mem_write_en=1 for exactly 4 cycles with mem_addr=0x80 and mem_data_in={11,22,33,44}. Hit pulses once at cycle 5. A following load of 0x80 hits in the same cycle and returns {11,22,33,44}.
- Conflict: load 0x0000_0040, then load 0x0000_0440 (same index, INDEX_BITS=8) → second load misses and fills. Reloading 0x40 misses again.
- Address 0x0000_0043 → treated as 0x40; mem_addr=0x40.
- Drop cache_en and change cache_addr mid-FILL → fill still writes the original line, hit stays 0. A later load of the original address hits immediately.
- Assert rst_b low during WRITE cycle 2 → mem_write_en=0 immediately, state IDLE. A previously cached address now misses.
- With DCACHE_STATS_EN, run 1 miss + 3 hits → miss_count=1, hit_count=3.
